// File: rtl/spi_slave_if.sv
// SPI slave endpoint: oversamples sclk/ss/mosi in the pclk domain, shifts 8-bit frames in any
// CPOL/CPHA mode with selectable bit order, and exchanges bytes through a TX buffer and RX register.
module spi_slave_if #(
  parameter logic [7:0] IDLE_FILL = 8'hFF
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       lsbfe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       busy,
  output logic       tx_underrun,
  output logic       rx_overrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;

  logic [2:0] sclk_sync, ss_sync, mosi_sync;
  logic       cpol_q, cpha_q, lsbfe_q;
  logic [7:0] tx_buf, tx_shift, rx_shift;
  logic       tx_full, pending;
  logic [2:0] bit_cnt;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic use_cpha, use_lsbfe;
  logic byte_start, init_start, do_shift, do_sample, abort, byte_done, tx_load;
  logic [7:0] start_byte, start_shifted, rx_next;

  assign ss_fall     = ss_sync[2] & ~ss_sync[1];
  assign ss_rise     = ~ss_sync[2] & ss_sync[1];
  assign sclk_rise   = ~sclk_sync[2] & sclk_sync[1];
  assign sclk_fall   = sclk_sync[2] & ~sclk_sync[1];
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  // The ss-fall byte start happens before the mode registers have captured the new mode
  assign use_cpha  = (state == IDLE) ? cpha : cpha_q;
  assign use_lsbfe = (state == IDLE) ? lsbfe : lsbfe_q;

  assign start_byte    = tx_full ? tx_buf : IDLE_FILL;
  assign start_shifted = use_lsbfe ? {1'b0, start_byte[7:1]} : {start_byte[6:0], 1'b0};
  assign rx_next       = lsbfe_q ? {mosi_sync[1], rx_shift[7:1]} : {rx_shift[6:0], mosi_sync[1]};
  assign byte_done     = do_sample & (bit_cnt == 3'd7);
  assign tx_load       = tx_valid & ~tx_full;

  assign tx_ready = ~tx_full;
  assign busy     = (state == ACTIVE);

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_start = 1'b0;
    init_start = 1'b0;
    do_shift   = 1'b0;
    do_sample  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = ACTIVE;
          byte_start = 1'b1;
          init_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else begin
          if (shift_edge) begin
            byte_start = pending;
            do_shift   = ~pending;
          end
          do_sample = sample_edge;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      sclk_sync   <= 3'b000;
      ss_sync     <= 3'b111;
      mosi_sync   <= 3'b000;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsbfe_q     <= 1'b0;
      tx_buf      <= 8'h00;
      tx_full     <= 1'b0;
      tx_shift    <= 8'h00;
      rx_shift    <= 8'h00;
      bit_cnt     <= 3'd0;
      pending     <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[1:0], sclk};
      ss_sync     <= {ss_sync[1:0], ss};
      mosi_sync   <= {mosi_sync[1:0], mosi};
      miso_oe     <= ~ss_sync[1];
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      if (state == IDLE) begin
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        lsbfe_q <= lsbfe;
      end

      // With cpha=1 the first frame bit waits for the first leading edge
      if (byte_start) begin
        tx_underrun <= ~tx_full;
        bit_cnt     <= 3'd0;
        pending     <= 1'b0;
        if (init_start && use_cpha) begin
          tx_shift <= start_byte;
        end else begin
          miso     <= use_lsbfe ? start_byte[0] : start_byte[7];
          tx_shift <= start_shifted;
        end
      end else if (do_shift) begin
        miso     <= lsbfe_q ? tx_shift[0] : tx_shift[7];
        tx_shift <= lsbfe_q ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
      end

      if (do_sample) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) pending <= 1'b1;
      end

      if (abort) begin
        bit_cnt <= 3'd0;
        pending <= 1'b0;
      end

      if (byte_start && tx_full) tx_full <= 1'b0;
      if (tx_load) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      // A completing byte takes priority over a same-cycle read
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (byte_done) begin
        rx_data    <= rx_next;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~rx_ready;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: a behavioural SPI master drives frames in every mode while
// expected RX bytes and master-read TX bytes are queued and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_slave_if;

  localparam int HALF = 80;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, busy, tx_underrun, rx_overrun;

  int total = 0;
  int bad = 0;
  int under_cnt = 0;
  int over_cnt = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  spi_slave_if #(.IDLE_FILL(8'hFF)) dut (
    .pclk(pclk), .preset(preset), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .busy(busy), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (!preset) begin
      if (tx_underrun) under_cnt++;
      if (rx_overrun) over_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time exceeded, required finish before 1ms");
    $fatal(1, "[TB] timeout");
  end

  task automatic set_mode(input logic p, input logic h, input logic l);
    cpol = p; cpha = h; lsbfe = l; sclk = p;
    repeat (6) @(posedge pclk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    int n = 0;
    @(negedge pclk);
    while (!tx_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    total++;
    if (!tx_ready) begin
      bad++;
      $display("FAIL load_tx_wait: tx_ready=%b required 1 within 200 cycles", tx_ready);
    end else begin
      tx_data = d; tx_valid = 1'b1;
      @(negedge pclk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] d, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi = d[idx]; #HALF; sclk = ~cpol; rd[idx] = miso; #HALF; sclk = cpol;
      end else begin
        #HALF; sclk = ~cpol; mosi = d[idx]; #HALF; sclk = cpol; rd[idx] = miso;
      end
    end
  endtask

  task automatic spi_frame(input logic [7:0] d, output logic [7:0] rd);
    ss = 1'b0;
    spi_byte(d, 8, rd);
    #HALF; ss = 1'b1; #HALF;
    repeat (4) @(negedge pclk);
  endtask

  task automatic pulse_rx_ready();
    @(negedge pclk); rx_ready = 1'b1;
    @(negedge pclk); rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got=%b want=1", tx_ready); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got=%b want=0", rx_valid); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got=%b want=0", miso); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_miso_oe: got=%b want=0", miso_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
    total++; if ({tx_underrun, rx_overrun} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got=%b want=00", {tx_underrun, rx_overrun}); end
    preset = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic test_mode0();
    logic [7:0] rd, exp;
    int u0, o0;
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'hA5); tx_q.push_back(8'hA5);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL mode0_tx_full: got=%b want=0", tx_ready); end
    u0 = under_cnt; o0 = over_cnt;
    rx_q.push_back(8'h3C);
    fork
      spi_frame(8'h3C, rd);
      begin
        repeat (12) @(negedge pclk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mode0_busy: got=%b want=1", busy); end
        total++; if (miso_oe !== 1'b1) begin bad++; $display("FAIL mode0_miso_oe: got=%b want=1", miso_oe); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mode0_tx_consumed: got=%b want=1", tx_ready); end
        // refill so the byte start after the last bit does not underrun; this byte is never clocked out
        load_tx(8'h00);
      end
    join
    exp = tx_q.pop_front();
    total++; if (rd !== exp) begin bad++; $display("FAIL mode0_miso_byte: got=%h want=%h", rd, exp); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL mode0_rx_valid: got=%b want=1", rx_valid); end
    exp = rx_q.pop_front();
    total++; if (rx_data !== exp) begin bad++; $display("FAIL mode0_rx_data: got=%h want=%h", rx_data, exp); end
    total++; if (under_cnt - u0 !== 0) begin bad++; $display("FAIL mode0_underrun: got=%0d want=0", under_cnt - u0); end
    total++; if (over_cnt - o0 !== 0) begin bad++; $display("FAIL mode0_overrun: got=%0d want=0", over_cnt - o0); end
    pulse_rx_ready();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mode0_rx_clear: got=%b want=0", rx_valid); end
  endtask

  task automatic test_modes();
    logic [2:0] modes [7];
    logic [7:0] rd, exp;
    modes = '{3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    for (int m = 0; m < 7; m++) begin
      set_mode(modes[m][2], modes[m][1], modes[m][0]);
      load_tx(8'h81); tx_q.push_back(8'h81);
      rx_q.push_back(8'h01);
      spi_frame(8'h01, rd);
      exp = tx_q.pop_front();
      total++; if (rd !== exp) begin bad++; $display("FAIL modes_miso_byte[%b]: got=%h want=%h", modes[m], rd, exp); end
      total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL modes_rx_valid[%b]: got=%b want=1", modes[m], rx_valid); end
      exp = rx_q.pop_front();
      total++; if (rx_data !== exp) begin bad++; $display("FAIL modes_rx_data[%b]: got=%h want=%h", modes[m], rx_data, exp); end
      pulse_rx_ready();
    end
  endtask

  task automatic test_underrun();
    logic [7:0] rd, exp;
    int u0;
    set_mode(1'b0, 1'b1, 1'b0);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL underrun_empty: got=%b want=1", tx_ready); end
    u0 = under_cnt;
    tx_q.push_back(8'hFF);
    rx_q.push_back(8'h5A);
    spi_frame(8'h5A, rd);
    exp = tx_q.pop_front();
    total++; if (rd !== exp) begin bad++; $display("FAIL underrun_fill: got=%h want=%h", rd, exp); end
    total++; if (under_cnt - u0 !== 1) begin bad++; $display("FAIL underrun_pulses: got=%0d want=1", under_cnt - u0); end
    exp = rx_q.pop_front();
    total++; if (rx_data !== exp) begin bad++; $display("FAIL underrun_rx_data: got=%h want=%h", rx_data, exp); end
    pulse_rx_ready();
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd1, rd2, exp, lost;
    int o0;
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'h33);
    tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    o0 = over_cnt;
    fork
      begin
        ss = 1'b0;
        spi_byte(8'h11, 8, rd1);
        spi_byte(8'h22, 8, rd2);
        #HALF; ss = 1'b1; #HALF;
        repeat (4) @(negedge pclk);
      end
      begin
        repeat (12) @(negedge pclk);
        load_tx(8'h44);
      end
    join
    exp = tx_q.pop_front();
    total++; if (rd1 !== exp) begin bad++; $display("FAIL b2b_miso_byte1: got=%h want=%h", rd1, exp); end
    exp = tx_q.pop_front();
    total++; if (rd2 !== exp) begin bad++; $display("FAIL b2b_miso_byte2: got=%h want=%h", rd2, exp); end
    total++; if (over_cnt - o0 !== 1) begin bad++; $display("FAIL b2b_overrun: got=%0d want=1", over_cnt - o0); end
    lost = rx_q.pop_front();
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_rx_valid: got=%b want=1", rx_valid); end
    total++; if (rx_data !== rx_q[0]) begin bad++; $display("FAIL b2b_rx_data: got=%h want=%h (overwrote %h)", rx_data, rx_q[0], lost); end
  endtask

  task automatic test_abort();
    logic [7:0] rd, exp;
    int o0;
    fork
      begin
        ss = 1'b0;
        spi_byte(8'hF0, 4, rd);
        #HALF; ss = 1'b1;
        repeat (6) @(negedge pclk);
      end
      begin
        repeat (12) @(negedge pclk);
        load_tx(8'h5A);
      end
    join
    tx_q.push_back(8'h5A);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got=%b want=0", busy); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL abort_miso_oe: got=%b want=0", miso_oe); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL abort_rx_valid: got=%b want=1", rx_valid); end
    exp = rx_q.pop_front();
    total++; if (rx_data !== exp) begin bad++; $display("FAIL abort_rx_data: got=%h want=%h", rx_data, exp); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL abort_tx_kept: got=%b want=0", tx_ready); end
    pulse_rx_ready();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL abort_rx_clear: got=%b want=0", rx_valid); end
    o0 = over_cnt;
    rx_q.push_back(8'hC3);
    spi_frame(8'hC3, rd);
    exp = tx_q.pop_front();
    total++; if (rd !== exp) begin bad++; $display("FAIL abort_next_miso: got=%h want=%h", rd, exp); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL abort_next_rx_valid: got=%b want=1", rx_valid); end
    exp = rx_q.pop_front();
    total++; if (rx_data !== exp) begin bad++; $display("FAIL abort_next_rx_data: got=%h want=%h", rx_data, exp); end
    total++; if (over_cnt - o0 !== 0) begin bad++; $display("FAIL abort_next_overrun: got=%0d want=0", over_cnt - o0); end
  endtask

  task automatic test_preset();
    logic [7:0] rd, exp;
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'h7E);
    fork
      begin
        ss = 1'b0;
        spi_byte(8'h99, 3, rd);
      end
      begin
        repeat (12) @(negedge pclk);
        load_tx(8'hE7);
      end
    join
    @(negedge pclk); preset = 1'b1;
    @(negedge pclk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL preset_tx_ready: got=%b want=1", tx_ready); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL preset_rx_valid: got=%b want=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL preset_rx_data: got=%h want=00", rx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL preset_busy: got=%b want=0", busy); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL preset_miso_oe: got=%b want=0", miso_oe); end
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL preset_miso: got=%b want=0", miso); end
    ss = 1'b1; sclk = 1'b0;
    repeat (5) @(negedge pclk);
    preset = 1'b0;
    repeat (3) @(negedge pclk);
    load_tx(8'h96); tx_q.push_back(8'h96);
    rx_q.push_back(8'h69);
    spi_frame(8'h69, rd);
    exp = tx_q.pop_front();
    total++; if (rd !== exp) begin bad++; $display("FAIL preset_next_miso: got=%h want=%h", rd, exp); end
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL preset_next_rx_valid: got=%b want=1", rx_valid); end
    exp = rx_q.pop_front();
    total++; if (rx_data !== exp) begin bad++; $display("FAIL preset_next_rx_data: got=%h want=%h", rx_data, exp); end
    pulse_rx_ready();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_preset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
